reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
Multi-entry register file with two registered read ports, one write port and a per-entry busy scoreboard. It is the storage stage fed by the write-back path and consumed by operand fetch. Entry 0 is hardwired zero: writes to it are discarded and reads always return 0. The scoreboard lets issue logic reserve a destination so fetch can stall on not-yet-written operands.

Parameters:
SIZE, 8, data width in bits
ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries (localparam)

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_n_i  input  1  reset, asynchronous, active-low
wr_en_i  input  1  write strobe from write-back
wr_addr_i  input  ADDR_W  write destination
din_i  input  SIZE  write data
rsv_en_i  input  1  reserve strobe from issue (marks entry busy)
rsv_addr_i  input  ADDR_W  entry to reserve
rd_addr_a_i  input  ADDR_W  read port A address
rd_addr_b_i  input  ADDR_W  read port B address
dout_a_o  output  SIZE  port A data, registered
dout_b_o  output  SIZE  port B data, registered
busy_a_o  output  1  port A entry busy, registered, aligned with dout_a_o
busy_b_o  output  1  port B entry busy, registered, aligned with dout_b_o

Behaviour:
- Reset (rst_n_i low, asynchronous): all entries 0, all busy bits 0, dout_a_o/dout_b_o = 0, busy_a_o/busy_b_o = 0. Held while low; first update on the first rising edge after release.
- Write: on an edge with wr_en_i=1 and wr_addr_i!=0, entry[wr_addr_i] <= din_i and busy[wr_addr_i] <= 0. wr_addr_i=0 means no storage change and no busy change.
- Reserve: on an edge with rsv_en_i=1 and rsv_addr_i!=0, busy[rsv_addr_i] <= 1. Reserving address 0 is ignored; busy[0] is constant 0.
- Same edge, write and reserve to the same nonzero address: data is written and busy ends 1 (the reservation belongs to the newer instruction).
- Read latency is 1 cycle: on each edge, dout_x_o <= value of entry[rd_addr_x_i] and busy_x_o <= busy[rd_addr_x_i]. No read enable; the ports update every cycle.
- Write bypass: if wr_en_i=1 and wr_addr_i==rd_addr_x_i!=0 on the same edge, dout_x_o takes din_i, not the old entry.
  - busy_x_o takes the post-edge busy value: 0, unless a reserve to the same address also occurs on that edge.
- Reserve bypass: if rsv_en_i=1 and rsv_addr_i==rd_addr_x_i!=0, busy_x_o <= 1 on that edge.
- rd_addr_x_i=0: dout_x_o <= 0 and busy_x_o <= 0 regardless of other activity.
- Both ports may read the same address; both return identical data and busy.
- Reset asserted mid-operation clears everything immediately; pending reservations are lost.

Decomposition:
- Shared package reg_file_pkg:
  - default SIZE and ADDR_W constants
  - ZERO_ADDR constant (0)
- One natural sub-module, reg_scoreboard:
  - holds the DEPTH busy bits with the reserve/write set-clear priority
  - exposes a combinational next-busy lookup for the two read ports
- Data storage and bypass muxing stay in the top module.

Test Plan:
- Reset then read addr 3 and addr 0 -> dout_a_o=0x00, dout_b_o=0x00, busy both 0.
- Write 0xA5 to addr 2, next cycle read A=2 -> one cycle later dout_a_o=0xA5, busy_a_o=0.
- Write 0xFF to addr 0, then read A=0 -> dout_a_o=0x00; reserve addr 0 -> busy_a_o stays 0.
- Same-edge bypass: write 0x3C to addr 5 while rd_addr_a_i=5 and rd_addr_b_i=5 -> after that edge dout_a_o=dout_b_o=0x3C.
- Scoreboard sequence on addr 4:
  - reserve 4 -> busy_a_o=1 next cycle
  - write 0x11 to 4 -> busy_a_o=0, dout_a_o=0x11
  - same-edge reserve and write 0x22 to 4 -> dout_a_o=0x22, busy_a_o=1
- Reserve addr 6, write 0x77 to addr 6, then pulse rst_n_i low mid-cycle -> outputs go to 0 without waiting for a clock edge; after release, read 6 -> data 0x00, busy 0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants for the register file and its busy scoreboard.
// Entry ZERO_ADDR is hardwired to zero and can never be marked busy.
package reg_file_pkg;
    localparam int SIZE_DEF   = 8;
    localparam int ADDR_W_DEF = 3;
    localparam int ZERO_ADDR  = 0;
endpackage

// File: rtl/reg_scoreboard.sv
// Per-entry busy bits: issue reserves a destination, write-back releases it.
// Also exposes the post-edge busy value of each read address for the read ports.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic              rsv_en_i,
    input  logic [ADDR_W-1:0] rsv_addr_i,
    input  logic [ADDR_W-1:0] rd_addr_a_i,
    input  logic [ADDR_W-1:0] rd_addr_b_i,
    output logic              busy_next_a_o,
    output logic              busy_next_b_o
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy_reg;
    logic [DEPTH-1:0] busy_next;

    // A reservation outranks a same-edge write: it belongs to the newer instruction.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
            if (gi == ZERO_ADDR) begin : g_zero
                assign busy_next[gi] = 1'b0;
            end else begin : g_entry
                assign busy_next[gi] =
                    (rsv_en_i && rsv_addr_i == ADDR_W'(gi)) ? 1'b1 :
                    (wr_en_i  && wr_addr_i  == ADDR_W'(gi)) ? 1'b0 :
                    busy_reg[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    assign busy_next_a_o = busy_next[rd_addr_a_i];
    assign busy_next_b_o = busy_next[rd_addr_b_i];
endmodule

// File: rtl/reg_file_sb.sv
// Register file with two registered read ports, one write port and a busy
// scoreboard; reads bypass same-edge writes and reservations.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int SIZE   = SIZE_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [SIZE-1:0]   din_i,
    input  logic              rsv_en_i,
    input  logic [ADDR_W-1:0] rsv_addr_i,
    input  logic [ADDR_W-1:0] rd_addr_a_i,
    input  logic [ADDR_W-1:0] rd_addr_b_i,
    output logic [SIZE-1:0]   dout_a_o,
    output logic [SIZE-1:0]   dout_b_o,
    output logic              busy_a_o,
    output logic              busy_b_o
);
    localparam int DEPTH = 2**ADDR_W;

    logic [SIZE-1:0]             mem_reg [DEPTH];
    logic [1:0][ADDR_W-1:0]      rd_addr;
    logic [1:0][SIZE-1:0]        rd_data_next;
    logic                        busy_next_a;
    logic                        busy_next_b;
    logic                        wr_live;

    assign wr_live = wr_en_i && (wr_addr_i != ADDR_W'(ZERO_ADDR));
    assign rd_addr = {rd_addr_b_i, rd_addr_a_i};

    // Entry 0 is reset to zero and never written, so it stays zero.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (wr_live) begin
            mem_reg[wr_addr_i] <= din_i;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
            assign rd_data_next[gi] =
                (rd_addr[gi] == ADDR_W'(ZERO_ADDR))   ? '0    :
                (wr_live && wr_addr_i == rd_addr[gi]) ? din_i :
                mem_reg[rd_addr[gi]];
        end
    endgenerate

    reg_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .wr_en_i       (wr_en_i),
        .wr_addr_i     (wr_addr_i),
        .rsv_en_i      (rsv_en_i),
        .rsv_addr_i    (rsv_addr_i),
        .rd_addr_a_i   (rd_addr_a_i),
        .rd_addr_b_i   (rd_addr_b_i),
        .busy_next_a_o (busy_next_a),
        .busy_next_b_o (busy_next_b)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dout_a_o <= '0;
            dout_b_o <= '0;
            busy_a_o <= 1'b0;
            busy_b_o <= 1'b0;
        end else begin
            dout_a_o <= rd_data_next[0];
            dout_b_o <= rd_data_next[1];
            busy_a_o <= busy_next_a;
            busy_b_o <= busy_next_b;
        end
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: each issued cycle queues its expected read
// results, and a monitor compares them one clock edge later.
module tb_reg_file_sb;
    localparam int SIZE   = 8;
    localparam int ADDR_W = 3;

    logic              clk_i = 1'b0;
    logic              rst_n_i = 1'b0;
    logic              wr_en_i = 1'b0;
    logic [ADDR_W-1:0] wr_addr_i = '0;
    logic [SIZE-1:0]   din_i = '0;
    logic              rsv_en_i = 1'b0;
    logic [ADDR_W-1:0] rsv_addr_i = '0;
    logic [ADDR_W-1:0] rd_addr_a_i = '0;
    logic [ADDR_W-1:0] rd_addr_b_i = '0;
    logic [SIZE-1:0]   dout_a_o;
    logic [SIZE-1:0]   dout_b_o;
    logic              busy_a_o;
    logic              busy_b_o;

    typedef struct {
        string          name;
        bit             chk_a;
        logic [SIZE-1:0] da;
        logic           ba;
        bit             chk_b;
        logic [SIZE-1:0] db;
        logic           bb;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    reg_file_sb #(.SIZE(SIZE), .ADDR_W(ADDR_W)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .wr_en_i     (wr_en_i),
        .wr_addr_i   (wr_addr_i),
        .din_i       (din_i),
        .rsv_en_i    (rsv_en_i),
        .rsv_addr_i  (rsv_addr_i),
        .rd_addr_a_i (rd_addr_a_i),
        .rd_addr_b_i (rd_addr_b_i),
        .dout_a_o    (dout_a_o),
        .dout_b_o    (dout_b_o),
        .busy_a_o    (busy_a_o),
        .busy_b_o    (busy_b_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input string port,
                         input logic [SIZE-1:0] got_d, input logic got_b,
                         input logic [SIZE-1:0] exp_d, input logic exp_b);
        total_cnt++;
        if (got_d === exp_d && got_b === exp_b) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s port %s: got dout=%h busy=%b, want dout=%h busy=%b",
                     name, port, got_d, got_b, exp_d, exp_b);
        end
    endtask

    // Drive one cycle of stimulus and queue what the read ports must show after the edge.
    task automatic step(input string name,
                        input logic we, input int wa, input logic [SIZE-1:0] d,
                        input logic re, input int ra_rsv,
                        input int ra, input int rb,
                        input bit ca, input logic [SIZE-1:0] da, input logic ba,
                        input bit cb, input logic [SIZE-1:0] db, input logic bb);
        exp_t e;
        @(negedge clk_i);
        wr_en_i     = we;
        wr_addr_i   = ADDR_W'(wa);
        din_i       = d;
        rsv_en_i    = re;
        rsv_addr_i  = ADDR_W'(ra_rsv);
        rd_addr_a_i = ADDR_W'(ra);
        rd_addr_b_i = ADDR_W'(rb);
        e.name = name; e.chk_a = ca; e.da = da; e.ba = ba;
        e.chk_b = cb; e.db = db; e.bb = bb;
        exp_q.push_back(e);
        $display("step %-14s we=%b wa=%0d din=%h re=%b rsv=%0d ra=%0d rb=%0d",
                 name, we, wa, d, re, ra_rsv, ra, rb);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk_i);
            n++;
        end
        #2;
        total_cnt++;
        if (exp_q.size() == 0) pass_cnt++;
        else $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    endtask

    // Monitor: the read ports present a result every edge; compare against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (e.chk_a) check(e.name, "A", dout_a_o, busy_a_o, e.da, e.ba);
                if (e.chk_b) check(e.name, "B", dout_b_o, busy_b_o, e.db, e.bb);
            end
        end
    end

    initial begin
        #12;
        check("in_reset", "A", dout_a_o, busy_a_o, 8'h00, 1'b0);
        check("in_reset", "B", dout_b_o, busy_b_o, 8'h00, 1'b0);
        #10 rst_n_i = 1'b1;

        //    name            we wa din    re rsv ra rb  A: chk data busy  B: chk data busy
        step("rst_read",      0, 0, 8'h00, 0, 0,  3, 0,  1, 8'h00, 0,     1, 8'h00, 0);
        step("wr2",           1, 2, 8'hA5, 0, 0,  1, 0,  1, 8'h00, 0,     1, 8'h00, 0);
        step("rd2",           0, 0, 8'h00, 0, 0,  2, 1,  1, 8'hA5, 0,     1, 8'h00, 0);
        step("wr0_rd0",       1, 0, 8'hFF, 0, 0,  0, 2,  1, 8'h00, 0,     1, 8'hA5, 0);
        step("rd0",           0, 0, 8'h00, 0, 0,  0, 0,  1, 8'h00, 0,     1, 8'h00, 0);
        step("rsv0_rd0",      0, 0, 8'h00, 1, 0,  0, 0,  1, 8'h00, 0,     1, 8'h00, 0);
        step("bypass5",       1, 5, 8'h3C, 0, 0,  5, 5,  1, 8'h3C, 0,     1, 8'h3C, 0);
        step("rd5",           0, 0, 8'h00, 0, 0,  5, 2,  1, 8'h3C, 0,     1, 8'hA5, 0);
        step("rsv4_byp",      0, 0, 8'h00, 1, 4,  4, 3,  1, 8'h00, 1,     1, 8'h00, 0);
        step("rd4_busy",      0, 0, 8'h00, 0, 0,  4, 4,  1, 8'h00, 1,     1, 8'h00, 1);
        step("wr4_11",        1, 4, 8'h11, 0, 0,  4, 3,  1, 8'h11, 0,     1, 8'h00, 0);
        step("rd4_free",      0, 0, 8'h00, 0, 0,  4, 4,  1, 8'h11, 0,     1, 8'h11, 0);
        step("rsv_wr4_22",    1, 4, 8'h22, 1, 4,  4, 4,  1, 8'h22, 1,     1, 8'h22, 1);
        step("rd4_after",     0, 0, 8'h00, 0, 0,  4, 2,  1, 8'h22, 1,     1, 8'hA5, 0);
        step("rsv6",          0, 0, 8'h00, 1, 6,  6, 5,  1, 8'h00, 1,     1, 8'h3C, 0);
        step("wr6_77",        1, 6, 8'h77, 0, 0,  6, 0,  1, 8'h77, 0,     1, 8'h00, 0);
        step("rsv6_again",    0, 0, 8'h00, 1, 6,  6, 6,  1, 8'h77, 1,     1, 8'h77, 1);
        step("idle_rd6",      0, 0, 8'h00, 0, 0,  6, 4,  1, 8'h77, 1,     1, 8'h22, 1);
        drain();

        // Asynchronous reset between edges: outputs must clear without a clock.
        @(posedge clk_i);
        #2 rst_n_i = 1'b0;
        #1;
        check("async_rst", "A", dout_a_o, busy_a_o, 8'h00, 1'b0);
        check("async_rst", "B", dout_b_o, busy_b_o, 8'h00, 1'b0);
        @(negedge clk_i);
        #2 rst_n_i = 1'b1;

        step("post_rst_rd6",  0, 0, 8'h00, 0, 0,  6, 6,  1, 8'h00, 0,     1, 8'h00, 0);
        step("post_rst_rd",   0, 0, 8'h00, 0, 0,  5, 4,  1, 8'h00, 0,     1, 8'h00, 0);
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #5000;
        $display("FAIL timeout: got no finish by 5000ns, want finish");
        $fatal(1, "timeout");
    end
endmodule
